inst_prefetch: RTL and testbench

Instruction prefetch unit: the writer side of the 16-byte instruction byte queue. It drives the queue's push side (`queue_in`/`queue_push`) and flush, and reads opcode/operand bytes from program memory at a sequential fetch PC. The decoder drains the queue from the other end. On a taken branch or jump, the block flushes the queue and restarts fetching at the new PC.

---
 rtl/inst_prefetch_if.sv | 25 ++
 rtl/inst_prefetch.sv | 124 ++++++++++++
 tb/tb_inst_prefetch.sv | 305 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/inst_prefetch_if.sv
// Prefetch bus bundle: program-memory read port plus the push/flush side of the
// instruction byte queue. The prefetcher is the master, memory/queue the slave.
interface inst_prefetch_if #(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned FREE_W = 5
);
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_ack;
    logic [7:0]        mem_data;
    logic [7:0]        queue_in;
    logic              queue_push;
    logic              queue_flush;
    logic [FREE_W-1:0] queue_free;

    modport master (
        output mem_req, mem_addr, queue_in, queue_push, queue_flush,
        input  mem_ack, mem_data, queue_free
    );

    modport slave (
        input  mem_req, mem_addr, queue_in, queue_push, queue_flush,
        output mem_ack, mem_data, queue_free
    );
endinterface

// File: rtl/inst_prefetch.sv
// Instruction prefetch unit: fetches bytes at a sequential PC into the instruction queue.
// Optional INST_PREFETCH_HALT_EN adds a fetch_halt input (RDY) that blocks new requests.
module inst_prefetch #(
    parameter int unsigned       ADDR_W   = 16,
    parameter int unsigned       FREE_W   = 5,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(16'h0000)
) (
    input  logic              clk,
    input  logic              reset,
`ifdef INST_PREFETCH_HALT_EN
    input  logic              fetch_halt,
`endif
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic [ADDR_W-1:0] fetch_pc,
    inst_prefetch_if.master   bus
);

    localparam int unsigned CW = FREE_W + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        FLUSH = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic              mem_req_q, mem_req_d;
    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [7:0]        queue_in_q, queue_in_d;
    logic              queue_push_q, queue_push_d;
    logic              queue_flush_q, queue_flush_d;

    logic              ack_c;
    logic              halt_c;
    logic              can_issue_c;
    logic signed [CW-1:0] credit_c;

`ifdef INST_PREFETCH_HALT_EN
    assign halt_c = fetch_halt;
`else
    assign halt_c = 1'b0;
`endif

    // Credit discounts the push in flight and the byte being acked this cycle.
    assign ack_c       = mem_req_q & bus.mem_ack;
    assign credit_c    = $signed({1'b0, bus.queue_free})
                       - $signed(CW'(queue_push_q))
                       - $signed(CW'(ack_c));
    assign can_issue_c = !credit_c[CW-1] && (credit_c != '0) && !halt_c;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            mem_req_q     <= 1'b0;
            fetch_pc_q    <= RESET_PC;
            queue_in_q    <= 8'h00;
            queue_push_q  <= 1'b0;
            queue_flush_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            mem_req_q     <= mem_req_d;
            fetch_pc_q    <= fetch_pc_d;
            queue_in_q    <= queue_in_d;
            queue_push_q  <= queue_push_d;
            queue_flush_q <= queue_flush_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        mem_req_d     = mem_req_q;
        fetch_pc_d    = fetch_pc_q;
        queue_in_d    = queue_in_q;
        queue_push_d  = 1'b0;
        queue_flush_d = 1'b0;

        if (redirect_valid) begin
            // Any same-cycle ack is dropped; memory forgets the abandoned request.
            state_d       = FLUSH;
            mem_req_d     = 1'b0;
            fetch_pc_d    = redirect_pc;
            queue_flush_d = 1'b1;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (can_issue_c) begin
                        state_d   = REQ;
                        mem_req_d = 1'b1;
                    end
                end
                REQ: begin
                    if (ack_c) begin
                        queue_in_d   = bus.mem_data;
                        queue_push_d = 1'b1;
                        fetch_pc_d   = fetch_pc_q + ADDR_W'(1);
                        if (can_issue_c) begin
                            mem_req_d = 1'b1;
                        end else begin
                            state_d   = IDLE;
                            mem_req_d = 1'b0;
                        end
                    end
                end
                FLUSH: begin
                    state_d   = IDLE;
                    mem_req_d = 1'b0;
                end
                default: begin
                    state_d   = IDLE;
                    mem_req_d = 1'b0;
                end
            endcase
        end
    end

    assign bus.mem_req     = mem_req_q;
    assign bus.mem_addr    = fetch_pc_q;
    assign bus.queue_in    = queue_in_q;
    assign bus.queue_push  = queue_push_q;
    assign bus.queue_flush = queue_flush_q;
    assign fetch_pc        = fetch_pc_q;

endmodule

// File: tb/tb_inst_prefetch.sv
// Bench for inst_prefetch: memory and queue models, byte scoreboard, redirect vector table
// and hand-written sequences for queue-full, redirect, reset and halt corner cases.
module tb_inst_prefetch;

    localparam int unsigned ADDR_W   = 16;
    localparam int unsigned FREE_W   = 5;
    localparam logic [15:0] RESET_PC = 16'h0000;

    logic        clk;
    logic        reset;
    logic        redirect_valid;
    logic [15:0] redirect_pc;
    logic [15:0] fetch_pc;
`ifdef INST_PREFETCH_HALT_EN
    logic        fetch_halt;
`endif

    inst_prefetch_if #(.ADDR_W(ADDR_W), .FREE_W(FREE_W)) bus ();

    inst_prefetch #(.ADDR_W(ADDR_W), .FREE_W(FREE_W), .RESET_PC(RESET_PC)) dut (
        .clk            (clk),
        .reset          (reset),
`ifdef INST_PREFETCH_HALT_EN
        .fetch_halt     (fetch_halt),
`endif
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .fetch_pc       (fetch_pc),
        .bus            (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] target;
        logic [7:0]  b0;
        logic [7:0]  b1;
        logic [7:0]  b2;
    } redir_vec_t;

    int          n_checks;
    int          n_fail;
    int          n_push;
    int          flush_cnt;
    int          wc;
    int          ack_mode;
    int          pull_req;
    int          free_m;
    logic        rst_req;
    logic        rd_req;
    logic [15:0] rd_pc;
    logic [15:0] model_pc;
    logic        last_push;
    logic        last_flush;
    logic [7:0]  sb[$];
    logic [7:0]  got[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock: observe DUT outputs at the falling edge, then drive the next inputs.
    task automatic step();
        logic ack;
        @(negedge clk);
        if (last_flush) free_m = 16;
        else            free_m = free_m - int'(last_push);
        free_m   = free_m + pull_req;
        pull_req = 0;
        if (bus.queue_push) begin
            n_push++;
            got.push_back(bus.queue_in);
            chk("push_room", 32'(free_m > 0), 32'd1);
            chk("push_expected", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) chk("push_data", 32'(bus.queue_in), 32'(sb.pop_front()));
        end
        last_push  = bus.queue_push;
        last_flush = bus.queue_flush;
        if (bus.queue_flush) flush_cnt++;

        reset          = rst_req;
        redirect_valid = rd_req;
        redirect_pc    = rd_pc;
        if (bus.mem_req) begin
            ack = (ack_mode == 1) || (ack_mode == 2 && wc == 2);
            wc  = ack ? 0 : wc + 1;
        end else begin
            ack = 1'b0;
            wc  = 0;
        end
        bus.mem_ack  = ack;
        bus.mem_data = ack ? bus.mem_addr[7:0] : 8'hA5;
        if (ack && !rst_req && !rd_req) begin
            chk("mem_addr_seq", 32'(bus.mem_addr), 32'(model_pc));
            sb.push_back(model_pc[7:0]);
            model_pc = model_pc + 16'd1;
        end
        if (rst_req) begin
            model_pc   = RESET_PC;
            free_m     = 16;
            last_push  = 1'b0;
            last_flush = 1'b0;
        end else if (rd_req) begin
            model_pc = rd_pc;
        end
        rd_req         = 1'b0;
        bus.queue_free = FREE_W'(free_m);
    endtask

    task automatic do_reset();
        rst_req = 1'b1;
        step();
        step();
        rst_req = 1'b0;
        step();
        n_push = 0;
        got.delete();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        redir_vec_t vecs[4];
        int         p0;
        int         f0;
        logic       found;
        logic       seen;

        vecs[0] = '{16'hFFFE, 8'hFE, 8'hFF, 8'h00};
        vecs[1] = '{16'h1234, 8'h34, 8'h35, 8'h36};
        vecs[2] = '{16'h00FF, 8'hFF, 8'h00, 8'h01};
        vecs[3] = '{16'h8000, 8'h00, 8'h01, 8'h02};

        n_checks = 0; n_fail = 0; n_push = 0; flush_cnt = 0; wc = 0;
        ack_mode = 1; pull_req = 0; free_m = 16;
        rst_req = 1'b1; rd_req = 1'b0; rd_pc = 16'h0000; model_pc = RESET_PC;
        last_push = 1'b0; last_flush = 1'b0;
        reset = 1'b1; redirect_valid = 1'b0; redirect_pc = 16'h0000;
        bus.mem_ack = 1'b0; bus.mem_data = 8'h00; bus.queue_free = FREE_W'(16);
`ifdef INST_PREFETCH_HALT_EN
        fetch_halt = 1'b0;
`endif

        // Reset values
        step();
        step();
        chk("rst_mem_req", 32'(bus.mem_req), 32'd0);
        chk("rst_queue_push", 32'(bus.queue_push), 32'd0);
        chk("rst_queue_flush", 32'(bus.queue_flush), 32'd0);
        chk("rst_queue_in", 32'(bus.queue_in), 32'h00);
        chk("rst_fetch_pc", 32'(fetch_pc), 32'(RESET_PC));
        chk("rst_mem_addr", 32'(bus.mem_addr), 32'(RESET_PC));

        // Release, streaming fill of an empty queue with no pulls
        rst_req = 1'b0;
        step();
        n_push = 0;
        chk("idle_first_cycle", 32'(bus.mem_req), 32'd0);
        step();
        chk("first_req", 32'(bus.mem_req), 32'd1);
        chk("first_addr", 32'(bus.mem_addr), 32'h0000);
        step();
        chk("first_push", 32'(bus.queue_push), 32'd1);
        chk("first_byte", 32'(bus.queue_in), 32'h00);
        chk("pc_after_first", 32'(fetch_pc), 32'h0001);
        step();
        chk("second_push", 32'(bus.queue_push), 32'd1);
        chk("second_byte", 32'(bus.queue_in), 32'h01);
        chk("pc_after_second", 32'(fetch_pc), 32'h0002);
        repeat (40) step();
        chk("full_push_count", 32'(n_push), 32'd16);
        chk("full_no_req", 32'(bus.mem_req), 32'd0);
        pull_req = 1;
        repeat (8) step();
        chk("one_pull_one_push", 32'(n_push), 32'd17);
        chk("refull_no_req", 32'(bus.mem_req), 32'd0);

        // Redirect to C000 in the same cycle memory acks address 0005
        ack_mode = 1;
        do_reset();
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            step();
            if (bus.mem_req && bus.mem_addr == 16'h0004) found = 1'b1;
        end
        chk("reach_addr4", 32'(found), 32'd1);
        rd_req = 1'b1; rd_pc = 16'hC000;
        step();
        chk("ack5_addr", 32'(bus.mem_addr), 32'h0005);
        p0 = n_push; f0 = flush_cnt;
        step();
        chk("rd_flush", 32'(bus.queue_flush), 32'd1);
        chk("rd_no_req", 32'(bus.mem_req), 32'd0);
        chk("rd_no_push", 32'(bus.queue_push), 32'd0);
        chk("rd_fetch_pc", 32'(fetch_pc), 32'hC000);
        step();
        chk("rd_flush_done", 32'(bus.queue_flush), 32'd0);
        chk("rd_still_no_req", 32'(bus.mem_req), 32'd0);
        step();
        chk("rd_new_req", 32'(bus.mem_req), 32'd1);
        chk("rd_new_addr", 32'(bus.mem_addr), 32'hC000);
        step();
        chk("rd_first_byte", 32'(bus.queue_in), 32'h00);
        chk("rd_flush_once", 32'(flush_cnt - f0), 32'd1);
        chk("rd_ack5_dropped", 32'(n_push - p0), 32'd1);

        // Redirect vector table, including the FFFF->0000 wrap
        foreach (vecs[k]) begin
            rd_req = 1'b1; rd_pc = vecs[k].target;
            step();
            got.delete();
            step();
            chk("tbl_flush", 32'(bus.queue_flush), 32'd1);
            chk("tbl_pc", 32'(fetch_pc), 32'(vecs[k].target));
            step();
            step();
            chk("tbl_req", 32'(bus.mem_req), 32'd1);
            chk("tbl_addr", 32'(bus.mem_addr), 32'(vecs[k].target));
            for (int i = 0; i < 10 && got.size() < 3; i++) step();
            chk("tbl_count", 32'(got.size() >= 3), 32'd1);
            if (got.size() >= 3) begin
                chk("tbl_b0", 32'(got[0]), 32'(vecs[k].b0));
                chk("tbl_b1", 32'(got[1]), 32'(vecs[k].b1));
                chk("tbl_b2", 32'(got[2]), 32'(vecs[k].b2));
            end
        end

        // Redirect arriving while FLUSH is active
        rd_req = 1'b1; rd_pc = 16'h1000;
        step();
        rd_req = 1'b1; rd_pc = 16'h2000;
        step();
        chk("rr_flush1", 32'(bus.queue_flush), 32'd1);
        chk("rr_pc1", 32'(fetch_pc), 32'h1000);
        step();
        chk("rr_flush2", 32'(bus.queue_flush), 32'd1);
        chk("rr_pc2", 32'(fetch_pc), 32'h2000);
        step();
        chk("rr_flush_end", 32'(bus.queue_flush), 32'd0);
        step();
        chk("rr_addr", 32'(bus.mem_addr), 32'h2000);
        chk("rr_req", 32'(bus.mem_req), 32'd1);

        // Slow memory, reset lands on the cycle an ack arrives
        ack_mode = 2;
        do_reset();
        found = 1'b0;
        for (int i = 0; i < 60 && !found; i++) begin
            step();
            if (bus.mem_req && wc == 2 && n_push >= 2) found = 1'b1;
        end
        chk("slow_reach", 32'(found), 32'd1);
        rst_req = 1'b1;
        step();
        step();
        chk("mid_rst_req", 32'(bus.mem_req), 32'd0);
        chk("mid_rst_pc", 32'(fetch_pc), 32'(RESET_PC));
        chk("mid_rst_no_push", 32'(bus.queue_push), 32'd0);
        rst_req = 1'b0;
        step();

`ifdef INST_PREFETCH_HALT_EN
        // Halt during an unacked request: byte lands, then no new request
        ack_mode = 2;
        do_reset();
        found = 1'b0;
        for (int i = 0; i < 60 && !found; i++) begin
            step();
            if (bus.mem_req && wc == 0 && n_push >= 1) found = 1'b1;
        end
        chk("halt_reach", 32'(found), 32'd1);
        fetch_halt = 1'b1;
        p0 = n_push;
        for (int i = 0; i < 10 && n_push == p0; i++) step();
        chk("halt_byte_pushed", 32'(n_push - p0), 32'd1);
        seen = 1'b0;
        repeat (6) begin
            step();
            if (bus.mem_req) seen = 1'b1;
        end
        chk("halt_no_req", 32'(seen), 32'd0);
        fetch_halt = 1'b0;
        step();
        step();
        chk("halt_resume", 32'(bus.mem_req), 32'd1);
`endif
        seen = 1'b0;

        repeat (4) step();
        chk("scoreboard_drained", 32'(sb.size() <= 2), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
